// File: rtl/obc_da_sequencer_if.sv
// Frame-in / result-out handshake bundle for the OBC distributed-arithmetic sequencer.
interface obc_da_sequencer_if #(
    parameter int unsigned DW    = 16,
    parameter int unsigned ACC_W = 48
);
    logic                 in_valid;
    logic                 in_ready;
    logic [16*DW-1:0]     in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_W-1:0]     out_data;

    // master: frame producer / result consumer
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // slave: the sequencer
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/obc_da_sequencer.sv
// Bit-serial OBC distributed-arithmetic controller for one DFT bin: slices a 16-sample frame LSB first
// into the bin ROM and shift-accumulates its partial sums. Optional macro OBC_DA_OFFSET_EN adds the OBC constant term.
module obc_da_sequencer #(
    parameter int unsigned DW    = 16,
    parameter int unsigned ROM_W = 32,
    parameter int unsigned ACC_W = 48
) (
    input  logic                    clk,
    input  logic                    rst_n,
    obc_da_sequencer_if.slave       bus,
    output logic [15:0]             slice_out,
    output logic                    m_out,
    input  logic signed [ROM_W-1:0] rom_in,
    output logic                    busy
`ifdef OBC_DA_OFFSET_EN
    ,
    input  logic signed [ROM_W-1:0] offset_in
`endif
);
    localparam int unsigned NS   = 16;
    localparam int unsigned KW   = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [KW-1:0] LAST = KW'(DW - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
`ifdef OBC_DA_OFFSET_EN
        ,
        S_OFFSET
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [DW-1:0]       sreg_q [NS];
    logic [DW-1:0]       sreg_d [NS];
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [KW-1:0]       k_q, k_d;
    logic [15:0]         slice_d;
    logic                m_d;
    logic                out_valid_q, out_valid_d;
    logic [ACC_W-1:0]    out_data_q, out_data_d;
    logic                busy_d;
    logic [ACC_W-1:0]    rom_ext;
    logic [ACC_W-1:0]    addend;
    logic                last_slice;

`ifdef OBC_DA_OFFSET_EN
    logic [ROM_W-1:0]    offset_q, offset_d;
    logic [ACC_W-1:0]    offset_ext;
    assign offset_ext = {{(ACC_W-ROM_W){offset_q[ROM_W-1]}}, offset_q};
`endif

    assign rom_ext    = {{(ACC_W-ROM_W){rom_in[ROM_W-1]}}, rom_in};
    assign addend     = rom_ext << k_q;
    assign last_slice = (k_q == LAST);

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (bus.in_valid) state_d = S_RUN;
            S_RUN: begin
                if (last_slice) begin
`ifdef OBC_DA_OFFSET_EN
                    state_d = S_OFFSET;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef OBC_DA_OFFSET_EN
            S_OFFSET: state_d = S_DONE;
`endif
            S_DONE: if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        sreg_d      = sreg_q;
        acc_d       = acc_q;
        k_d         = k_q;
        slice_d     = slice_out;
        m_d         = m_out;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
`ifdef OBC_DA_OFFSET_EN
        offset_d    = offset_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    // slice 0 goes straight to the output; the shifters keep bits 1..DW-1
                    for (int i = 0; i < NS; i++) begin
                        sreg_d[i]  = bus.in_data[i*DW +: DW] >> 1;
                        slice_d[i] = bus.in_data[i*DW];
                    end
                    acc_d = '0;
                    k_d   = '0;
                    m_d   = (DW == 1);
`ifdef OBC_DA_OFFSET_EN
                    offset_d = offset_in;
`endif
                end
            end
            S_RUN: begin
                acc_d = acc_q + addend;
                for (int i = 0; i < NS; i++) begin
                    sreg_d[i]  = sreg_q[i] >> 1;
                    slice_d[i] = sreg_q[i][0];
                end
                k_d = k_q + KW'(1);
                m_d = ((k_q + KW'(1)) == LAST);
                if (last_slice) begin
                    slice_d = '0;
                    m_d     = 1'b0;
`ifndef OBC_DA_OFFSET_EN
                    out_data_d  = acc_q + addend;
                    out_valid_d = 1'b1;
`endif
                end
            end
`ifdef OBC_DA_OFFSET_EN
            S_OFFSET: begin
                acc_d       = acc_q + offset_ext;
                out_data_d  = acc_q + offset_ext;
                out_valid_d = 1'b1;
            end
`endif
            S_DONE: if (bus.out_ready) out_valid_d = 1'b0;
            default: ;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NS; i++) sreg_q[i] <= '0;
            acc_q       <= '0;
            k_q         <= '0;
            slice_out   <= '0;
            m_out       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy        <= 1'b0;
`ifdef OBC_DA_OFFSET_EN
            offset_q    <= '0;
`endif
        end else begin
            sreg_q      <= sreg_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            slice_out   <= slice_d;
            m_out       <= m_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy        <= busy_d;
`ifdef OBC_DA_OFFSET_EN
            offset_q    <= offset_d;
`endif
        end
    end
endmodule

// File: tb/tb_obc_da_sequencer.sv
// Directed bench for obc_da_sequencer with a popcount ROM stub (OBC sign inversion on m).
module tb_obc_da_sequencer;
    localparam int unsigned DW    = 16;
    localparam int unsigned ROM_W = 32;
    localparam int unsigned ACC_W = 48;
`ifdef OBC_DA_OFFSET_EN
    localparam int EXP_LAT = 17;
`else
    localparam int EXP_LAT = 16;
`endif

    logic                    clk;
    logic                    rst_n;
    logic [15:0]             slice_out;
    logic                    m_out;
    logic signed [ROM_W-1:0] rom_in;
    logic                    busy;
`ifdef OBC_DA_OFFSET_EN
    logic signed [ROM_W-1:0] offset_in;
`endif

    obc_da_sequencer_if #(.DW(DW), .ACC_W(ACC_W)) bus ();

    obc_da_sequencer #(.DW(DW), .ROM_W(ROM_W), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .slice_out (slice_out),
        .m_out     (m_out),
        .rom_in    (rom_in),
        .busy      (busy)
`ifdef OBC_DA_OFFSET_EN
        ,
        .offset_in (offset_in)
`endif
    );

    always_comb begin
        rom_in = m_out ? -ROM_W'($countones(slice_out)) : ROM_W'($countones(slice_out));
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] sl [16];
    logic [15:0] mpat;
    int lat;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic send_frame(input logic [255:0] data, output int lat_o);
        bus.in_data  = data;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = {8{32'hDEADBEEF}};
        lat_o = 0;
        mpat  = '0;
        for (int e = 1; e <= 40; e++) begin
            if (e <= 16) begin
                sl[e-1]     = slice_out;
                mpat[e-1]   = m_out;
            end
            @(posedge clk); #1;
            if (bus.out_valid) begin
                lat_o = e;
                break;
            end
        end
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("release_out_valid", 48'(bus.out_valid), 48'd0);
        check("release_in_ready", 48'(bus.in_ready), 48'd1);
    endtask

    initial begin
        logic [255:0] frame;
        int seen_valid;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = {16{16'h0001}};
        bus.out_ready = 1'b0;
`ifdef OBC_DA_OFFSET_EN
        offset_in     = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 48'(bus.in_ready), 48'd1);
        check("rst_out_valid", 48'(bus.out_valid), 48'd0);
        check("rst_busy", 48'(busy), 48'd0);
        check("rst_slice", 48'(slice_out), 48'd0);
        check("rst_m", 48'(m_out), 48'd0);

        // all samples = 1
        send_frame({16{16'h0001}}, lat);
        check("ones_slice0", 48'(sl[0]), 48'h0FFFF);
        check("ones_slice1", 48'(sl[1]), 48'h0);
        check("ones_slice15", 48'(sl[15]), 48'h0);
        check("ones_mpat", 48'(mpat), 48'h8000);
        check("ones_lat", 48'(lat), 48'(EXP_LAT));
        check("ones_data", bus.out_data, 48'd16);
        check("ones_busy", 48'(busy), 48'd1);
        release_out();

        // all samples = -1
        send_frame({16{16'hFFFF}}, lat);
        check("neg_slice15", 48'(sl[15]), 48'h0FFFF);
        check("neg_mpat", 48'(mpat), 48'h8000);
        check("neg_data", bus.out_data, 48'hFFFF_FFFF_FFF0);
        release_out();

        // single MSB on sample 5
        frame = '0;
        frame[5*16 +: 16] = 16'h8000;
        send_frame(frame, lat);
        check("msb_slice0", 48'(sl[0]), 48'h0);
        check("msb_slice14", 48'(sl[14]), 48'h0);
        check("msb_slice15", 48'(sl[15]), 48'h0020);
        check("msb_data", bus.out_data, 48'hFFFF_FFFF_8000);
        release_out();

        // back-pressure: result held while a new frame is offered
        send_frame({16{16'h0002}}, lat);
        bus.in_valid = 1'b1;
        bus.in_data  = {16{16'h0001}};
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("stall_data", bus.out_data, 48'd32);
            check("stall_valid", 48'(bus.out_valid), 48'd1);
            check("stall_in_ready", 48'(bus.in_ready), 48'd0);
        end
        bus.in_valid = 1'b0;
        release_out();
        check("after_busy", 48'(busy), 48'd0);

        // reset in the middle of RUN
        bus.in_data  = {16{16'h0001}};
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_in_ready", 48'(bus.in_ready), 48'd1);
        check("abort_busy", 48'(busy), 48'd0);
        check("abort_slice", 48'(slice_out), 48'd0);
        seen_valid = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.out_valid) seen_valid++;
            @(posedge clk); #1;
        end
        check("abort_no_valid", 48'(seen_valid), 48'd0);
        send_frame({16{16'h0003}}, lat);
        check("threes_lat", 48'(lat), 48'(EXP_LAT));
        check("threes_data", bus.out_data, 48'd48);
        release_out();

`ifdef OBC_DA_OFFSET_EN
        offset_in = -32'sd5;
        send_frame({16{16'h0001}}, lat);
        offset_in = '0;
        check("offset_lat", 48'(lat), 48'd17);
        check("offset_data", bus.out_data, 48'd11);
        release_out();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
